// File: rtl/if_id_stage.sv
// ============================================================================
// if_id_stage
// ----------------------------------------------------------------------------
// Pipeline register between instruction fetch and decode. It carries
// {AddIn, ImemoryIn} pairs in order, one pair per cycle. A two-entry
// structure (a main register plus a skid register) absorbs one cycle of
// decode backpressure without losing an instruction. A flush squashes
// everything that is held or arriving. Every output comes straight from a
// flop, so there is no combinational path from an input to an output.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous, active-high reset
//   in_valid    in   fetch presents a pair
//   in_ready    out  stage can accept a pair (registered; skid empty)
//   AddIn       in   [ADDR_W]  fetch address / PC+4
//   ImemoryIn   in   [INSTR_W] fetched instruction
//   flush       in   squash all held and incoming pairs
//   out_valid   out  AddOut/ImemoryOut hold a valid pair
//   out_ready   in   decode consumes the pair this cycle
//   AddOut      out  [ADDR_W]  address to decode (0 when invalid)
//   ImemoryOut  out  [INSTR_W] instruction to decode (NOP when invalid)
//   stall_cnt   out  [CNT_W]   saturating count of stalled output cycles
//
// States
//   S_EMPTY | main invalid, skid invalid
//   S_ONE   | main valid,   skid invalid
//   S_FULL  | main valid,   skid valid
// ============================================================================
module if_id_stage #(
    parameter int                 ADDR_W  = 32,
    parameter int                 INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP     = '0,
    parameter int                 CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  AddIn,
    input  logic [INSTR_W-1:0] ImemoryIn,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  AddOut,
    output logic [INSTR_W-1:0] ImemoryOut,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    logic               r_out_valid;
    logic               r_in_ready;
    logic [ADDR_W-1:0]  r_main_add;
    logic [INSTR_W-1:0] r_main_instr;
    logic [ADDR_W-1:0]  r_skid_add;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [CNT_W-1:0]   r_stall_cnt;

    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  w_main_add_nxt;
    logic [INSTR_W-1:0] w_main_instr_nxt;
    logic [ADDR_W-1:0]  w_skid_add_nxt;
    logic [INSTR_W-1:0] w_skid_instr_nxt;
    logic               w_out_valid_nxt;
    logic               w_in_ready_nxt;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_stalled;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_stalled  = r_out_valid & ~out_ready;

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main_add   <= '0;
            r_main_instr <= NOP;
            r_skid_add   <= '0;
            r_skid_instr <= NOP;
            r_stall_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_main_add   <= w_main_add_nxt;
            r_main_instr <= w_main_instr_nxt;
            r_skid_add   <= w_skid_add_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            // Sampled before the edge, so a flush edge with a stalled
            // output still counts.
            if (w_stalled && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and next register contents
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_main_add_nxt   = r_main_add;
        w_main_instr_nxt = r_main_instr;
        w_skid_add_nxt   = r_skid_add;
        w_skid_instr_nxt = r_skid_instr;

        if (flush) begin
            // Flush overrides both handshakes; the incoming pair is dropped.
            w_state_nxt      = S_EMPTY;
            w_main_add_nxt   = '0;
            w_main_instr_nxt = NOP;
            w_skid_add_nxt   = '0;
            w_skid_instr_nxt = NOP;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt      = S_ONE;
                        w_main_add_nxt   = AddIn;
                        w_main_instr_nxt = ImemoryIn;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_add_nxt   = AddIn;
                        w_main_instr_nxt = ImemoryIn;
                    end else if (w_out_fire) begin
                        w_state_nxt      = S_EMPTY;
                        w_main_add_nxt   = '0;
                        w_main_instr_nxt = NOP;
                    end else if (w_in_fire) begin
                        w_state_nxt      = S_FULL;
                        w_skid_add_nxt   = AddIn;
                        w_skid_instr_nxt = ImemoryIn;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so only the output side can move.
                    if (w_out_fire) begin
                        w_state_nxt      = S_ONE;
                        w_main_add_nxt   = r_skid_add;
                        w_main_instr_nxt = r_skid_instr;
                        w_skid_add_nxt   = '0;
                        w_skid_instr_nxt = NOP;
                    end
                end
                default: begin
                    w_state_nxt      = S_EMPTY;
                    w_main_add_nxt   = '0;
                    w_main_instr_nxt = NOP;
                    w_skid_add_nxt   = '0;
                    w_skid_instr_nxt = NOP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake flags, decoded from the next state so they are registered
    // ------------------------------------------------------------------
    always_comb begin
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = 1'b1;
        case (w_state_nxt)
            S_EMPTY: begin
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
            end
            S_ONE: begin
                w_out_valid_nxt = 1'b1;
                w_in_ready_nxt  = 1'b1;
            end
            S_FULL: begin
                w_out_valid_nxt = 1'b1;
                w_in_ready_nxt  = 1'b0;
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
            end
        endcase
    end

    assign out_valid  = r_out_valid;
    assign in_ready   = r_in_ready;
    assign AddOut     = r_main_add;
    assign ImemoryOut = r_main_instr;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

    logic        clk;
    logic        rst;

    // 32-bit default instance
    logic        in_valid;
    logic        in_ready;
    logic [31:0] AddIn;
    logic [31:0] ImemoryIn;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] AddOut;
    logic [31:0] ImemoryOut;
    logic [15:0] stall_cnt;

    // 16-bit instance, NOP = 0xFFFF, 4-bit stall counter
    logic        b_in_valid;
    logic        b_in_ready;
    logic [15:0] b_AddIn;
    logic [15:0] b_ImemoryIn;
    logic        b_flush;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [15:0] b_AddOut;
    logic [15:0] b_ImemoryOut;
    logic [3:0]  b_stall_cnt;

    int checks;
    int errors;

    if_id_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .AddIn      (AddIn),
        .ImemoryIn  (ImemoryIn),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .AddOut     (AddOut),
        .ImemoryOut (ImemoryOut),
        .stall_cnt  (stall_cnt)
    );

    if_id_stage #(
        .ADDR_W  (16),
        .INSTR_W (16),
        .NOP     (16'hFFFF),
        .CNT_W   (4)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .AddIn      (b_AddIn),
        .ImemoryIn  (b_ImemoryIn),
        .flush      (b_flush),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .AddOut     (b_AddOut),
        .ImemoryOut (b_ImemoryOut),
        .stall_cnt  (b_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] I_A = 32'h20010005;
    localparam logic [31:0] I_B = 32'h8C220000;
    localparam logic [31:0] I_C = 32'h00221820;

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        AddIn     = '0;
        ImemoryIn = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        // Fill to FULL and accumulate stalls, then reset mid-cycle.
        in_valid = 1'b1; AddIn = 32'h4; ImemoryIn = I_A; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; AddIn = 32'h8; ImemoryIn = I_B;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++; $display("FAIL reset_pre_stall: got %0d want 2", stall_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_flags: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if (AddOut !== 32'h0 || ImemoryOut !== 32'h0) begin
            errors++; $display("FAIL reset_data: AddOut=%h ImemoryOut=%h want 0/0", AddOut, ImemoryOut);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || ImemoryOut !== 32'h0) begin
            errors++; $display("FAIL reset_discard: out_valid=%b ImemoryOut=%h want 0/0", out_valid, ImemoryOut);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] addrs [3];
        logic [31:0] instrs[3];
        addrs[0] = 32'h4; addrs[1] = 32'h8; addrs[2] = 32'hC;
        instrs[0] = I_A;  instrs[1] = I_B;  instrs[2] = I_C;
        idle_inputs();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; AddIn = addrs[i]; ImemoryIn = instrs[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || AddOut !== addrs[i] || ImemoryOut !== instrs[i]) begin
                errors++;
                $display("FAIL stream_%0d: v=%b r=%b add=%h ins=%h want 1/1 %h %h",
                         i, out_valid, in_ready, AddOut, ImemoryOut, addrs[i], instrs[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || AddOut !== 32'h0 || ImemoryOut !== 32'h0) begin
            errors++; $display("FAIL stream_drain: v=%b add=%h ins=%h want 0/0/0", out_valid, AddOut, ImemoryOut);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_skid();
        idle_inputs();
        do_reset();
        in_valid = 1'b1; AddIn = 32'h4; ImemoryIn = I_A; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; AddIn = 32'h8; ImemoryIn = I_B;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || AddOut !== 32'h4 || ImemoryOut !== I_A) begin
            errors++;
            $display("FAIL skid_fill: r=%b v=%b add=%h ins=%h want 0/1 4 %h", in_ready, out_valid, AddOut, ImemoryOut, I_A);
        end
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++; $display("FAIL skid_stall1: got %0d want 1", stall_cnt);
        end
        AddIn = 32'hC; ImemoryIn = I_C;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || AddOut !== 32'h4 || ImemoryOut !== I_A || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL skid_hold: r=%b add=%h ins=%h cnt=%0d want 0 4 %h 3", in_ready, AddOut, ImemoryOut, stall_cnt, I_A);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || AddOut !== 32'h8 || ImemoryOut !== I_B) begin
            errors++;
            $display("FAIL skid_drain_B: v=%b r=%b add=%h ins=%h want 1/1 8 %h", out_valid, in_ready, AddOut, ImemoryOut, I_B);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || AddOut !== 32'hC || ImemoryOut !== I_C) begin
            errors++; $display("FAIL skid_drain_C: v=%b add=%h ins=%h want 1 c %h", out_valid, AddOut, ImemoryOut, I_C);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || ImemoryOut !== 32'h0 || stall_cnt !== 16'd3) begin
            errors++; $display("FAIL skid_empty: v=%b ins=%h cnt=%0d want 0 0 3", out_valid, ImemoryOut, stall_cnt);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        do_reset();
        in_valid = 1'b1; AddIn = 32'h4; ImemoryIn = I_A; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; AddIn = 32'h8; ImemoryIn = I_B;
        tick();
        AddIn = 32'hC; ImemoryIn = I_C; flush = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || AddOut !== 32'h0 || ImemoryOut !== 32'h0) begin
            errors++;
            $display("FAIL flush_out: v=%b r=%b add=%h ins=%h want 0/1 0 0", out_valid, in_ready, AddOut, ImemoryOut);
        end
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++; $display("FAIL flush_stall_cnt: got %0d want 2", stall_cnt);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || ImemoryOut !== 32'h0) begin
                errors++; $display("FAIL flush_squash_%0d: v=%b ins=%h want 0 0", i, out_valid, ImemoryOut);
            end
        end
        // A new pair after the flush goes through cleanly.
        in_valid = 1'b1; AddIn = 32'h40; ImemoryIn = 32'h11112222;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || AddOut !== 32'h40 || ImemoryOut !== 32'h11112222) begin
            errors++; $display("FAIL flush_resume: v=%b add=%h ins=%h want 1 40 11112222", out_valid, AddOut, ImemoryOut);
        end
        tick();
    endtask

    task automatic test_params();
        idle_inputs();
        b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        do_reset();
        checks++;
        if (b_ImemoryOut !== 16'hFFFF || b_AddOut !== 16'h0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL param_reset: ins=%h add=%h v=%b r=%b want ffff 0 0 1", b_ImemoryOut, b_AddOut, b_out_valid, b_in_ready);
        end
        b_in_valid = 1'b1; b_AddIn = 16'h4; b_ImemoryIn = 16'h1234;
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_AddOut !== 16'h4 || b_ImemoryOut !== 16'h1234) begin
            errors++; $display("FAIL param_stream_0: v=%b add=%h ins=%h want 1 4 1234", b_out_valid, b_AddOut, b_ImemoryOut);
        end
        b_AddIn = 16'h8; b_ImemoryIn = 16'hABCD;
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_AddOut !== 16'h8 || b_ImemoryOut !== 16'hABCD) begin
            errors++; $display("FAIL param_stream_1: v=%b add=%h ins=%h want 1 8 abcd", b_out_valid, b_AddOut, b_ImemoryOut);
        end
        b_in_valid = 1'b0;
        tick();
        checks++;
        if (b_out_valid !== 1'b0 || b_AddOut !== 16'h0 || b_ImemoryOut !== 16'hFFFF) begin
            errors++; $display("FAIL param_drain: v=%b add=%h ins=%h want 0 0 ffff", b_out_valid, b_AddOut, b_ImemoryOut);
        end
    endtask

    task automatic test_saturation();
        b_in_valid = 1'b1; b_AddIn = 16'h20; b_ImemoryIn = 16'h0F0F; b_out_ready = 1'b1;
        tick();
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (b_stall_cnt !== 4'd14) begin
            errors++; $display("FAIL sat_before: got %0d want 14", b_stall_cnt);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (b_stall_cnt !== 4'd15 || b_out_valid !== 1'b1 || b_ImemoryOut !== 16'h0F0F) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d v=%b ins=%h want 15 1 0f0f", b_stall_cnt, b_out_valid, b_ImemoryOut);
        end
        b_out_ready = 1'b1;
        tick();
        checks++;
        if (b_stall_cnt !== 4'd15 || b_out_valid !== 1'b0) begin
            errors++; $display("FAIL sat_release: cnt=%0d v=%b want 15 0", b_stall_cnt, b_out_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_inputs();
        b_in_valid = 1'b0; b_AddIn = '0; b_ImemoryIn = '0; b_flush = 1'b0; b_out_ready = 1'b1;
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_params();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
